mux4: RTL and testbench

- 4:1 multiplexer selecting one of four W-bit lanes packed into a single data bus.
- Provides a combinational output `o` plus a registered copy `o_q` with a valid flag.
- Used as a generic datapath select element, e.g. for ALU operand and writeback source selection.
- Default W=1 is a pure bit-select: o = d[s].

---
 rtl/mux4.sv | 66 ++++++
 tb/tb_mux4.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux4.sv
// 4:1 lane multiplexer with a combinational output and a registered, valid-flagged copy.
// Optional MUX4_PARITY_EN adds a registered even-parity bit o_par for the captured lane.
module mux4 #(
    parameter int unsigned W = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     s,
    input  logic [4*W-1:0] d,
    input  logic           en,
    output logic [W-1:0]   o,
    output logic [W-1:0]   o_q,
    output logic           o_vld
`ifdef MUX4_PARITY_EN
    ,
    output logic           o_par
`endif
);

    localparam int unsigned LANES = 4;

    logic [W-1:0] lane [LANES];

    // Unpack the bus; lane 0 sits in the LSBs.
    always_comb begin
        for (int k = 0; k < int'(LANES); k++) begin
            lane[k] = d[k*W +: W];
        end
    end

    // Select; an unknown select propagates as all-X rather than picking a lane.
    always_comb begin
        o = '0;
        case (s)
            2'd0:    o = lane[0];
            2'd1:    o = lane[1];
            2'd2:    o = lane[2];
            2'd3:    o = lane[3];
            default: o = {W{1'bx}};
        endcase
    end

    // Capture register; reset wins over enable, o_vld pulses only on capturing edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q   <= '0;
            o_vld <= 1'b0;
        end else if (en) begin
            o_q   <= o;
            o_vld <= 1'b1;
        end else begin
            o_vld <= 1'b0;
        end
    end

`ifdef MUX4_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_par <= 1'b0;
        end else if (en) begin
            o_par <= ^o;
        end
    end
`endif

endmodule

// File: tb/tb_mux4.sv
// Directed bench for mux4: W=1 combinational sweep plus W=8 registered path via a scoreboard.
// Covers MUX4_PARITY_EN when the macro is defined for both RTL and bench.
module tb_mux4;

    typedef struct {
        logic [7:0] q;
        logic       vld;
        logic       par;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // W=1 instance
    logic       rst1, en1;
    logic [1:0] s1;
    logic [3:0] d1;
    logic       o1, o_q1, o_vld1;
`ifdef MUX4_PARITY_EN
    logic       o_par1;
`endif

    // W=8 instance
    logic        rst8, en8;
    logic [1:0]  s8;
    logic [31:0] d8;
    logic [7:0]  o8, o_q8;
    logic        o_vld8;
`ifdef MUX4_PARITY_EN
    logic        o_par8;
`endif

    mux4 #(.W(1)) u_dut1 (
        .clk(clk), .rst(rst1), .s(s1), .d(d1), .en(en1),
        .o(o1), .o_q(o_q1), .o_vld(o_vld1)
`ifdef MUX4_PARITY_EN
        , .o_par(o_par1)
`endif
    );

    mux4 #(.W(8)) u_dut8 (
        .clk(clk), .rst(rst8), .s(s8), .d(d8), .en(en8),
        .o(o8), .o_q(o_q8), .o_vld(o_vld8)
`ifdef MUX4_PARITY_EN
        , .o_par(o_par8)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // Reference state of the registered path
    logic [7:0] m_q   = '0;
    logic       m_vld = 1'b0;
    logic       m_par = 1'b0;

    function automatic logic [7:0] lane8(input logic [31:0] dv, input int sel);
        return 8'(dv >> (8 * sel));
    endfunction

    // Drive one cycle of W=8 stimulus and push the value expected after the next edge.
    task automatic drive(input logic r, input logic e, input logic [1:0] sv,
                         input logic [31:0] dv, input string tag);
        exp_t x;
        rst8 = r; en8 = e; s8 = sv; d8 = dv;
        if (r) begin
            m_q = '0; m_vld = 1'b0; m_par = 1'b0;
        end else if (e) begin
            m_q = lane8(dv, int'(sv)); m_vld = 1'b1; m_par = ^lane8(dv, int'(sv));
        end else begin
            m_vld = 1'b0;
        end
        x.q = m_q; x.vld = m_vld; x.par = m_par; x.tag = tag;
        sb.push_back(x);
    endtask

    // Advance one edge and compare the registered outputs against the scoreboard head.
    task automatic tick_check();
        exp_t x;
        @(posedge clk);
        #1;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL sb_empty observed=0 entries required=1");
        end
        if (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            assert (o_q8 === x.q) else begin
                errors++;
                $error("FAIL %s o_q observed=%h required=%h", x.tag, o_q8, x.q);
            end
            checks++;
            assert (o_vld8 === x.vld) else begin
                errors++;
                $error("FAIL %s o_vld observed=%b required=%b", x.tag, o_vld8, x.vld);
            end
`ifdef MUX4_PARITY_EN
            checks++;
            assert (o_par8 === x.par) else begin
                errors++;
                $error("FAIL %s o_par observed=%b required=%b", x.tag, o_par8, x.par);
            end
`endif
        end
    endtask

    task automatic check_o8(input logic [7:0] exp, input string tag);
        checks++;
        assert (o8 === exp) else begin
            errors++;
            $error("FAIL %s o observed=%h required=%h", tag, o8, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  dv;
        logic [31:0] lanes;

        rst1 = 1'b1; en1 = 1'b0; s1 = 2'd0; d1 = 4'd0;
        rst8 = 1'b1; en8 = 1'b0; s8 = 2'd0; d8 = '0;
        @(posedge clk);
        #1;

        // Reset state, both widths
        drive(1'b1, 1'b0, 2'd0, 32'h0, "reset0");
        tick_check();
        drive(1'b1, 1'b0, 2'd0, 32'h0, "reset1");
        tick_check();
        checks++;
        assert (o_q1 === 1'b0 && o_vld1 === 1'b0) else begin
            errors++;
            $error("FAIL w1_reset observed=%b%b required=00", o_q1, o_vld1);
        end
`ifdef MUX4_PARITY_EN
        checks++;
        assert (o_par1 === 1'b0) else begin
            errors++;
            $error("FAIL w1_reset_par observed=%b required=0", o_par1);
        end
`endif
        rst1 = 1'b0;

        // Exhaustive W=1 combinational sweep
        for (int dd = 0; dd < 16; dd++) begin
            for (int ss = 0; ss < 4; ss++) begin
                dv = 4'(dd);
                d1 = dv;
                s1 = 2'(ss);
                #1;
                checks++;
                assert (o1 === dv[ss]) else begin
                    errors++;
                    $error("FAIL w1_sweep d=%h s=%0d observed=%b required=%b", dv, ss, o1, dv[ss]);
                end
            end
        end

        // Lane ordering at W=8
        lanes = 32'hDDCCBBAA;
        d8 = lanes;
        for (int ss = 0; ss < 4; ss++) begin
            s8 = 2'(ss);
            #1;
            check_o8(lane8(lanes, ss), "lane_order");
        end

        // Single capture then hold with en=0
        drive(1'b0, 1'b1, 2'd2, 32'h44332211, "capture");
        tick_check();
        drive(1'b0, 1'b0, 2'd0, 32'h0, "hold");
        tick_check();

        // Reset beats enable; o stays combinational through reset
        drive(1'b1, 1'b1, 2'd1, 32'h0000FF00, "rst_prio");
        #1;
        check_o8(8'hFF, "rst_prio_comb");
        tick_check();
        check_o8(8'hFF, "rst_comb_during");

        // Streaming, first edge after reset captures immediately
        for (int ss = 0; ss < 4; ss++) begin
            drive(1'b0, 1'b1, 2'(ss), 32'h04030201, "stream");
            tick_check();
        end
        drive(1'b0, 1'b0, 2'd3, 32'h04030201, "stream_end");
        tick_check();

        // Parity lanes: 0x07 (odd) then 0x03 (even), then reset
        drive(1'b0, 1'b1, 2'd0, 32'h00000307, "par_07");
        tick_check();
        drive(1'b0, 1'b0, 2'd0, 32'h00000307, "par_hold");
        tick_check();
        drive(1'b0, 1'b1, 2'd1, 32'h00000307, "par_03");
        tick_check();
        drive(1'b1, 1'b0, 2'd0, 32'h00000307, "par_rst");
        tick_check();

        // Random captures
        for (int i = 0; i < 16; i++) begin
            drive(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 32'($urandom), "random");
            tick_check();
        end

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain observed=%0d required=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
